// File: rtl/bin_to_rns_64.sv
// rtl/bin_to_rns_64.sv - byte-serial binary to 9-modulus RNS forward converter with frame index
// Define BIN2RNS_SIGNED_EN for two's-complement input (abs stage plus residue negation in FIX).

`ifndef B0
`define B0 2
`endif
`ifndef B1
`define B1 255
`endif
`ifndef B2
`define B2 253
`endif
`ifndef B3
`define B3 251
`endif
`ifndef B4
`define B4 247
`endif
`ifndef B5
`define B5 241
`endif
`ifndef B6
`define B6 239
`endif
`ifndef B7
`define B7 233
`endif
`ifndef B8
`define B8 229
`endif

module bin_to_rns_64 #(
   parameter int DATA_W = 64,
   parameter int N      = 100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [64:0]       out_rns,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_idx,
   output logic              out_last
);

   localparam int NBYTES   = DATA_W / 8;
   localparam int MODS [8] = '{`B1, `B2, `B3, `B4, `B5, `B6, `B7, `B8};

   typedef enum logic [1:0] {IDLE, CONV, FIX, HOLD} state_t;

   state_t            state;
   state_t            state_d;
   logic [DATA_W-1:0] mag_in;
   logic [DATA_W-1:0] mag_sh;
   logic              mag_lsb;
   logic [3:0]        cnt;
   logic [7:0]        res     [8];
   logic [7:0]        res_fix [8];
   logic              accept;
   logic              last_byte;
`ifdef BIN2RNS_SIGNED_EN
   logic              sign;
`endif

   // {r, b} is r*256 + b; the largest value 255*256+255 fits the 16-bit intermediate
   function automatic logic [7:0] mod_step(input logic [7:0] r, input logic [7:0] b, input int m);
      logic [15:0] t;
      t = {r, b} % 16'(m);
      return t[7:0];
   endfunction

   assign accept    = (state == IDLE) && in_valid && in_ready;
   assign last_byte = (cnt == 4'(NBYTES - 1));

   always_comb begin
      mag_in = in_data;
`ifdef BIN2RNS_SIGNED_EN
      // the most-negative value negates to itself, which is the correct unsigned magnitude
      if (in_data[DATA_W-1]) mag_in = ~in_data + DATA_W'(1);
`endif
   end

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         res_fix[k] = res[k];
`ifdef BIN2RNS_SIGNED_EN
         if (sign && (res[k] != 8'd0)) res_fix[k] = 8'(MODS[k] - int'(res[k]));
`endif
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept) state_d = CONV;
         CONV:    if (last_byte) state_d = FIX;
         FIX:     state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_rns   <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         mag_sh    <= '0;
         mag_lsb   <= 1'b0;
         cnt       <= '0;
         for (int k = 0; k < 8; k++) res[k] <= '0;
`ifdef BIN2RNS_SIGNED_EN
         sign      <= 1'b0;
`endif
      end else begin
         state    <= state_d;
         in_ready <= (state_d == IDLE);
         case (state)
            IDLE: begin
               if (accept) begin
                  mag_sh  <= mag_in;
                  mag_lsb <= mag_in[0];
                  cnt     <= '0;
                  for (int k = 0; k < 8; k++) res[k] <= '0;
`ifdef BIN2RNS_SIGNED_EN
                  sign    <= in_data[DATA_W-1];
`endif
               end
            end
            CONV: begin
               // MSB byte first; the shift register keeps the next byte at the top
               for (int k = 0; k < 8; k++) res[k] <= mod_step(res[k], mag_sh[DATA_W-1 -: 8], MODS[k]);
               mag_sh <= mag_sh << 8;
               cnt    <= cnt + 4'd1;
            end
            FIX: begin
               out_rns   <= {res_fix[7], res_fix[6], res_fix[5], res_fix[4],
                             res_fix[3], res_fix[2], res_fix[1], res_fix[0], mag_lsb};
               out_valid <= 1'b1;
               out_last  <= (out_idx == 32'(N - 1));
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  out_idx   <= (out_idx == 32'(N - 1)) ? 32'd0 : out_idx + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_rns_64.sv
// tb/tb_bin_to_rns_64.sv - directed self-checking bench for bin_to_rns_64
// Honours BIN2RNS_SIGNED_EN to select the signed or unsigned reference.
`timescale 1ns/1ps

module tb_bin_to_rns_64;

   localparam int N = 100;
   localparam int MODS [1:8] = '{255, 253, 251, 247, 241, 239, 233, 229};

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [64:0] out_rns;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_idx;
   logic        out_last;

   int errors  = 0;
   int checks  = 0;
   int exp_idx = 0;

   always #5 clk = ~clk;

   bin_to_rns_64 #(.DATA_W(64), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_rns   (out_rns),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   function automatic logic [64:0] ref_rns(input logic [63:0] x);
      logic [63:0] a;
      logic [63:0] rem;
      logic        neg;
      logic [64:0] r;
      a   = x;
      neg = 1'b0;
`ifdef BIN2RNS_SIGNED_EN
      if (x[63]) begin
         a   = ~x + 64'd1;
         neg = 1'b1;
      end
`endif
      r    = '0;
      r[0] = a[0];
      for (int k = 1; k <= 8; k++) begin
         rem = a % 64'(MODS[k]);
         if (neg && rem != 64'd0) rem = 64'(MODS[k]) - rem;
         r[8*k -: 8] = rem[7:0];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_sample(input logic [63:0] x, input logic [64:0] exp, input int stall,
                             input bit chk_lat, input string tag);
      int lat;
      lat = 0;
      while (!in_ready && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_in_ready"}, 65'(in_ready), 65'd1);
      in_data  = x;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_valid"}, 65'(out_valid), 65'd1);
      if (chk_lat) chk({tag, "_latency"}, 65'(lat), 65'd9);
      chk({tag, "_rns"}, out_rns, exp);
      chk({tag, "_idx"}, 65'(out_idx), 65'(exp_idx));
      chk({tag, "_last"}, 65'(out_last), 65'(exp_idx == N - 1));
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk({tag, "_stall_valid"}, 65'(out_valid), 65'd1);
         chk({tag, "_stall_rns"}, out_rns, exp);
         chk({tag, "_stall_idx"}, 65'({out_last, out_idx}), 65'({exp_idx == N - 1, 32'(exp_idx)}));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_handoff"}, 65'(out_valid), 65'd0);
      exp_idx = (exp_idx == N - 1) ? 0 : exp_idx + 1;
      chk({tag, "_idx_next"}, 65'(out_idx), 65'(exp_idx));
   endtask

   initial begin
      logic [63:0] x;
      logic        seen;
      reset     = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 65'(in_ready), 65'd0);
      chk("rst_out_valid", 65'(out_valid), 65'd0);
      chk("rst_out_rns", out_rns, 65'd0);
      chk("rst_out_idx", 65'(out_idx), 65'd0);
      chk("rst_out_last", 65'(out_last), 65'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 65'(in_ready), 65'd1);

      run_sample(64'd0, 65'd0, 0, 1'b1, "zero");
      run_sample(64'd1, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1}, 2, 1'b1, "one");
`ifdef BIN2RNS_SIGNED_EN
      run_sample(64'hFFFF_FFFF_FFFF_FFFF,
                 {8'd228, 8'd232, 8'd238, 8'd240, 8'd246, 8'd250, 8'd252, 8'd254, 1'b1}, 1, 1'b1, "minus_one");
`else
      run_sample(64'hFFFF_FFFF_FFFF_FFFF, ref_rns(64'hFFFF_FFFF_FFFF_FFFF), 1, 1'b1, "all_ones");
`endif
      run_sample(64'd300, {8'd71, 8'd67, 8'd61, 8'd59, 8'd53, 8'd49, 8'd47, 8'd45, 1'b0}, 0, 1'b1, "three_hundred");
      run_sample(64'h8000_0000_0000_0000, ref_rns(64'h8000_0000_0000_0000), 0, 1'b1, "most_negative");

      // abort a conversion mid-flight
      in_data  = 64'd12345;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_idx = 0;
      chk("abort_out_valid", 65'(out_valid), 65'd0);
      chk("abort_out_idx", 65'(out_idx), 65'd0);
      @(posedge clk); #1;
      chk("abort_in_ready", 65'(in_ready), 65'd1);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      chk("abort_no_output", 65'(seen), 65'd0);
      run_sample(64'd12345, ref_rns(64'd12345), 0, 1'b1, "after_abort");

      // random stream with stalls, crossing the frame wrap
      for (int i = 0; i < 101; i++) begin
         x = {$urandom, $urandom};
         run_sample(x, ref_rns(x), int'($urandom_range(0, 3)), 1'b0, "stream");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
